xadac_sb: RTL and testbench

XADAC_SB -- requirements
Module: xadac_sb

---
 rtl/xadac_pkg.sv | 24 ++
 rtl/xadac_sb_lzc.sv | 27 ++
 rtl/xadac_sb.sv | 157 +++++++++++++++
 tb/tb_xadac_sb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/xadac_pkg.sv
// xadac_pkg: shared sizing and types for the XADAC issue scoreboard.
//   NoVs       - vector source operands per instruction
//   VrfIdWidth - vector register index width, VrfLen registers
//   IdWidth    - scoreboard tag width, SbLen entries
// Optional feature macro used by xadac_sb: XADAC_SB_BYPASS_EN.
package xadac_pkg;

  localparam int unsigned NoVs       = 3;
  localparam int unsigned VrfIdWidth = 5;
  localparam int unsigned IdWidth    = 4;
  localparam int unsigned SbLen      = 1 << IdWidth;
  localparam int unsigned VrfLen     = 1 << VrfIdWidth;

  typedef logic [VrfIdWidth-1:0] VrfIdT;
  typedef logic [IdWidth-1:0]    IdT;

  // One scoreboard slot: an in-flight instruction and the register it writes.
  typedef struct packed {
    logic  valid;
    logic  vd_en;
    VrfIdT vd;
  } sb_entry_t;

endpackage

// File: rtl/xadac_sb_lzc.sv
// xadac_sb_lzc: finds the lowest set bit of a vector.
//   vec_i   in  Width     candidate bitmap (1 = free)
//   idx_o   out IdxWidth  index of the lowest set bit (0 when none)
//   found_o out 1         at least one bit set
module xadac_sb_lzc #(
  parameter int unsigned Width    = xadac_pkg::SbLen,
  parameter int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    vec_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                found_o
);
  import xadac_pkg::*;

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IdxWidth'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadac_sb.sv
// xadac_sb: register scoreboard for an in-order issue / out-of-order retire
// vector unit. Tracks pending destination writes and blocks RAW/WAW hazards.
//   clk_i, rst_i (sync, active-high), flush_i (drop all in-flight entries)
//   issue_valid_i/issue_ready_o handshake; issue_vd_en_i/issue_vd_i destination,
//   issue_vs_en_i/issue_vs_i sources; issue_id_o tag given to the accepted issue
//   retire_valid_i/retire_id_i out-of-order retirement (no backpressure)
//   busy_o pending-write bitmap, count_o/full_o/empty_o occupancy,
//   err_o one-cycle pulse when a non-valid tag is retired
// Optional macro XADAC_SB_BYPASS_EN: a same-cycle valid retirement is removed
// from hazard and full evaluation so a dependent instruction can issue at once.
module xadac_sb #(
  parameter int unsigned NoVs       = xadac_pkg::NoVs,
  parameter int unsigned VrfIdWidth = xadac_pkg::VrfIdWidth,
  parameter int unsigned IdWidth    = xadac_pkg::IdWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       issue_vd_en_i,
  input  logic [VrfIdWidth-1:0]      issue_vd_i,
  input  logic [NoVs-1:0]            issue_vs_en_i,
  input  logic [NoVs*VrfIdWidth-1:0] issue_vs_i,
  output logic [IdWidth-1:0]         issue_id_o,
  input  logic                       retire_valid_i,
  input  logic [IdWidth-1:0]         retire_id_i,
  output logic [(1<<VrfIdWidth)-1:0] busy_o,
  output logic [IdWidth:0]           count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       err_o
);
  import xadac_pkg::*;

  localparam int unsigned NumEntries = 1 << IdWidth;
  localparam int unsigned NumRegs    = 1 << VrfIdWidth;

  logic [NumEntries-1:0] valid_q, valid_d;
  logic [NumEntries-1:0] vd_en_q, vd_en_d;
  logic [VrfIdWidth-1:0] vd_q [NumEntries];
  logic [VrfIdWidth-1:0] vd_d [NumEntries];
  logic [IdWidth:0]      count_q, count_d;
  logic                  err_q, err_d;

  logic                  retire_hit;
  logic [NumEntries-1:0] ret_mask;
  logic [NumRegs-1:0]    entry_oh [NumEntries];
  logic [NumRegs-1:0]    busy_all, busy_eff;
  logic                  hazard, full_eff, accept;
  logic [IdWidth-1:0]    free_idx;
  logic                  free_found;

  assign retire_hit = retire_valid_i && valid_q[retire_id_i];

  // Entries that hazard/full evaluation may ignore this cycle.
`ifdef XADAC_SB_BYPASS_EN
  assign ret_mask = retire_hit ? (NumEntries'(1) << retire_id_i) : '0;
`else
  assign ret_mask = '0;
`endif

  // Per-entry one-hot of the register it is about to write.
  for (genvar gi = 0; gi < NumEntries; gi++) begin : g_entry
    assign entry_oh[gi] = (valid_q[gi] && vd_en_q[gi]) ? (NumRegs'(1) << vd_q[gi]) : '0;
  end

  // WAW blocking guarantees at most one entry per register, so masking the
  // retiring entry cleanly drops its busy bit in the bypass view.
  always_comb begin
    busy_all = '0;
    busy_eff = '0;
    for (int i = 0; i < NumEntries; i++) begin
      busy_all = busy_all | entry_oh[i];
      if (!ret_mask[i]) busy_eff = busy_eff | entry_oh[i];
    end
  end

  always_comb begin
    hazard = issue_vd_en_i && busy_eff[issue_vd_i];
    for (int k = 0; k < NoVs; k++) begin
      if (issue_vs_en_i[k] && busy_eff[issue_vs_i[k*VrfIdWidth +: VrfIdWidth]]) hazard = 1'b1;
    end
  end

  xadac_sb_lzc #(
    .Width   (NumEntries),
    .IdxWidth(IdWidth)
  ) u_lzc (
    .vec_i  (~valid_q),
    .idx_o  (free_idx),
    .found_o(free_found)
  );

  // The retiring slot is still valid, so it is never picked while another
  // slot is free; under bypass it is handed out only when the table is full.
`ifdef XADAC_SB_BYPASS_EN
  assign issue_id_o = free_found ? free_idx : retire_id_i;
`else
  assign issue_id_o = free_idx;
  logic unused_found;
  assign unused_found = free_found;
`endif

  assign full_o        = (count_q == (IdWidth+1)'(NumEntries));
  assign empty_o       = (count_q == '0);
  assign full_eff      = full_o && !(|ret_mask);
  assign issue_ready_o = !full_eff && !hazard && !flush_i;
  assign accept        = issue_valid_i && issue_ready_o;

  assign busy_o  = busy_all;
  assign count_o = count_q;
  assign err_o   = err_q;

  always_comb begin
    valid_d = valid_q;
    vd_en_d = vd_en_q;
    vd_d    = vd_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (flush_i) begin
      valid_d = '0;
      vd_en_d = '0;
      count_d = '0;
    end else begin
      if (retire_hit) begin
        valid_d[retire_id_i] = 1'b0;
        vd_en_d[retire_id_i] = 1'b0;
      end else if (retire_valid_i) begin
        err_d = 1'b1;
      end
      // Applied after the retire so a bypass reallocation of the same slot wins.
      if (accept) begin
        valid_d[issue_id_o] = 1'b1;
        vd_en_d[issue_id_o] = issue_vd_en_i;
        vd_d[issue_id_o]    = issue_vd_i;
      end
      count_d = count_q + (IdWidth+1)'(accept) - (IdWidth+1)'(retire_hit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      vd_en_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      vd_en_q <= vd_en_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
    vd_q <= vd_d;
  end

endmodule

// File: tb/tb_xadac_sb.sv
// tb_xadac_sb: self-checking bench for xadac_sb (default parameters).
// Table-driven vectors plus hand sequences for fill/full, reuse, flush, reset.
// Expectations follow XADAC_SB_BYPASS_EN when the bench is built with it.
module tb_xadac_sb;

`ifdef XADAC_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, issue_ready, issue_vd_en;
  logic [4:0]  issue_vd;
  logic [2:0]  issue_vs_en;
  logic [14:0] issue_vs;
  logic [3:0]  issue_id;
  logic        retire_valid;
  logic [3:0]  retire_id;
  logic [31:0] busy;
  logic [4:0]  count;
  logic        full, empty, err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] sb_q [$];

  always #5 clk = ~clk;

  xadac_sb dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .issue_vd_en_i (issue_vd_en),
    .issue_vd_i    (issue_vd),
    .issue_vs_en_i (issue_vs_en),
    .issue_vs_i    (issue_vs),
    .issue_id_o    (issue_id),
    .retire_valid_i(retire_valid),
    .retire_id_i   (retire_id),
    .busy_o        (busy),
    .count_o       (count),
    .full_o        (full),
    .empty_o       (empty),
    .err_o         (err)
  );

  typedef struct {
    bit         iv;
    logic [4:0] vd;
    bit         sen;
    logic [4:0] s0;
    bit         rv;
    logic [3:0] rid;
    bit         fl;
    bit         exp_ready;
    logic [3:0] exp_id;
    logic [4:0] exp_count;
    logic [31:0] exp_busy;
    bit         exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic drive(input bit iv, input logic [4:0] vd, input bit sen, input logic [4:0] s0,
                       input bit rv, input logic [3:0] rid, input bit fl, input bit rs);
    issue_valid  = iv;
    issue_vd_en  = iv;
    issue_vd     = vd;
    issue_vs_en  = {2'b00, sen};
    issue_vs     = {10'd0, s0};
    retire_valid = rv;
    retire_id    = rid;
    flush        = fl;
    rst          = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue n independent instructions vd=base..base+n-1, expecting tags first..first+n-1.
  task automatic issue_seq(input string tag, input int base, input int n, input int first);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 5'(base + i), 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      sb_q.push_back(4'(first + i));
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("%s_ready%0d", tag, i), 32'(issue_ready), 32'd1);
      chk($sformatf("%s_id%0d", tag, i), 32'(issue_id), 32'(e));
      tick();
    end
  endtask

  initial begin
    vec_t v;
    logic [3:0] e;

    vecs[0]  = '{1'b1, 5'd3,  1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 5'd1, 32'h8, 1'b0};
    vecs[1]  = '{1'b1, 5'd10, 1'b1, 5'd3, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 5'd1, 32'h8, 1'b0};
    vecs[2]  = '{1'b1, 5'd10, 1'b1, 5'd3, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 5'd1, 32'h8, 1'b0};
    vecs[3]  = '{1'b1, 5'd10, 1'b1, 5'd3, 1'b1, 4'd0, 1'b0, BYP, 4'd1,
                 BYP ? 5'd1 : 5'd0, BYP ? 32'h400 : 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 5'd20, 1'b1, 5'd3, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0,
                 BYP ? 5'd2 : 5'd1, BYP ? 32'h100400 : 32'h100000, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd5, 1'b0, 1'b1, BYP ? 4'd2 : 4'd1,
                 BYP ? 5'd2 : 5'd1, BYP ? 32'h100400 : 32'h100000, 1'b1};
    vecs[6]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, BYP ? 4'd2 : 4'd1,
                 BYP ? 5'd2 : 5'd1, BYP ? 32'h100400 : 32'h100000, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd0, 1'b0, 1'b1, BYP ? 4'd2 : 4'd1,
                 BYP ? 5'd1 : 5'd0, BYP ? 32'h400 : 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd1, 1'b0, 1'b1, 4'd0, 5'd0, 32'h0, !BYP};
    vecs[9]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 5'd0, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 5'd0, 32'h0, 1'b0};

    // Reset state
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Table vectors: hazard, retire-unblock, bad retire, flush
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      drive(v.iv, v.vd, v.sen, v.s0, v.rv, v.rid, v.fl, 1'b0);
      sb_q.push_back(v.exp_id);
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("v%0d_ready", i), 32'(issue_ready), 32'(v.exp_ready));
      chk($sformatf("v%0d_id", i), 32'(issue_id), 32'(e));
      tick();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(v.exp_count));
      chk($sformatf("v%0d_busy", i), busy, v.exp_busy);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(v.exp_count == 5'd0));
    end

    // Bad retire while empty: one-cycle err pulse, count stays 0
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    chk("bad_ret_err", 32'(err), 32'd1);
    chk("bad_ret_count", 32'(count), 32'd0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("bad_ret_err_clr", 32'(err), 32'd0);

    // Fill all 16 tags
    issue_seq("fill", 0, 16, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_busy", busy, 32'h0000_FFFF);
    drive(1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_ready", 32'(issue_ready), 32'd0);
    tick();
    chk("full_count_hold", 32'(count), 32'd16);

    // Retire tag 7, then reuse it
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk("ret7_ready", 32'(issue_ready), 32'(BYP));
    if (BYP) chk("ret7_id", 32'(issue_id), 32'd7);
    tick();
    chk("ret7_count", 32'(count), 32'd15);
    chk("ret7_full", 32'(full), 32'd0);
    issue_seq("reuse", 20, 1, 7);
    chk("reuse_busy", busy, 32'h0010_FF7F);
    chk("reuse_full", 32'(full), 32'd1);

    // Same-cycle issue vd=9 and retire of the entry holding vd=9
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    chk("byp9_ready", 32'(issue_ready), 32'(BYP));
    if (BYP) chk("byp9_id", 32'(issue_id), 32'd9);
    tick();
    chk("byp9_busy9", 32'(busy[9]), 32'(BYP));
    chk("byp9_count", 32'(count), BYP ? 32'd16 : 32'd15);

    // Flush with 8 valid entries and a simultaneous issue
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    issue_seq("pre_fl", 0, 8, 0);
    chk("pre_fl_count", 32'(count), 32'd8);
    drive(1'b1, 5'd25, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_ready", 32'(issue_ready), 32'd0);
    tick();
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_busy", busy, 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_next_id", 32'(issue_id), 32'd0);
    tick();

    // Reset mid-stream with 4 valid entries and concurrent issue/retire
    issue_seq("pre_rst", 12, 4, 0);
    chk("pre_rst_busy", busy, 32'h0000_F000);
    drive(1'b1, 5'd16, 1'b0, 5'd0, 1'b1, 4'd9, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_busy", busy, 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
